// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU sharing controller.
//   - ALUOp encodings driven onto the shared ALU (NOP is the idle op).
//   - FSM state encoding for alu_share_ctrl.
//   - Requester port identifier (port 0 = execute, port 1 = address unit).
package alu_pkg;

   localparam logic [4:0] OP_NOP   = 5'b00000;
   localparam logic [4:0] OP_LUI   = 5'b00001;
   localparam logic [4:0] OP_AUIPC = 5'b00010;
   localparam logic [4:0] OP_ADD   = 5'b00011;

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StResp
   } state_e;

   typedef logic port_id_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant.
// Ports:
//   clk, rstn    clock, asynchronous active-low reset
//   en           arbitration allowed this cycle (grants are forced low otherwise)
//   req0, req1   request valids
//   gnt0, gnt1   combinational grants, at most one high; a grant is an accept
// The pointer names the port preferred on contention and moves to the other
// port whenever a grant is issued. A lone requester wins regardless of it.
module rr_arb2
   import alu_pkg::*;
(
   input  logic clk,
   input  logic rstn,
   input  logic en,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   port_id_t rr_ptr_q, rr_ptr_d;

   always_comb begin
      gnt0     = en && req0 && (!req1 || (rr_ptr_q == 1'b0));
      gnt1     = en && req1 && (!req0 || (rr_ptr_q == 1'b1));
      rr_ptr_d = rr_ptr_q;
      if (gnt0) begin
         rr_ptr_d = 1'b1;
      end else if (gnt1) begin
         rr_ptr_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr_ptr_q <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one ALU between two valid/ready requesters.
// Ports:
//   clk, rstn                         clock, asynchronous active-low reset
//   reqN_valid/ready/op/a/b           request channel of port N (N = 0, 1)
//   respN_valid/ready/c/zero          response channel of port N
//   alu_a, alu_b, alu_op              registered operands/op to the ALU
//   alu_c, alu_zero                   ALU result; only alu_zero[0] is used
//   ops_cnt                           completed response handshakes, wraps
// Flow: accept (IDLE) -> hold operands EXEC_CYCLES cycles (EXEC) -> capture
// C/Zero and present on the owner's response channel until consumed (RESP).
module alu_share_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned EXEC_CYCLES = 1,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [4:0]       req0_op,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [4:0]       req1_op,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   output logic             resp0_valid,
   input  logic             resp0_ready,
   output logic [31:0]      resp0_c,
   output logic             resp0_zero,
   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic [31:0]      resp1_c,
   output logic             resp1_zero,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [4:0]       alu_op,
   input  logic [31:0]      alu_c,
   input  logic [7:0]       alu_zero,
   output logic [CNT_W-1:0] ops_cnt
);

   localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

   state_e           state_q, state_d;
   port_id_t         owner_q, owner_d;
   logic [3:0]       exec_cnt_q, exec_cnt_d;
   logic [31:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [4:0]       alu_op_q, alu_op_d;
   logic [31:0]      resp0_c_q, resp0_c_d, resp1_c_q, resp1_c_d;
   logic             resp0_zero_q, resp0_zero_d, resp1_zero_q, resp1_zero_d;
   logic [CNT_W-1:0] ops_cnt_q, ops_cnt_d;

   logic gnt0, gnt1, accept, resp_hs;

   // Zero flag upper bits carry nothing for this controller.
   logic unused_zero_hi;
   assign unused_zero_hi = ^alu_zero[7:1];

   // rstn gates the enable so readies stay low throughout reset.
   rr_arb2 u_arb (
      .clk  (clk),
      .rstn (rstn),
      .en   (rstn && (state_q == StIdle)),
      .req0 (req0_valid),
      .req1 (req1_valid),
      .gnt0 (gnt0),
      .gnt1 (gnt1)
   );

   assign accept  = gnt0 || gnt1;
   assign resp_hs = (state_q == StResp) && (owner_q ? resp1_ready : resp0_ready);

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      exec_cnt_d   = exec_cnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      resp0_c_d    = resp0_c_q;
      resp0_zero_d = resp0_zero_q;
      resp1_c_d    = resp1_c_q;
      resp1_zero_d = resp1_zero_q;
      ops_cnt_d    = ops_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d    = StExec;
               owner_d    = gnt1;
               exec_cnt_d = 4'd0;
               alu_op_d   = gnt1 ? req1_op : req0_op;
               alu_a_d    = gnt1 ? req1_a : req0_a;
               alu_b_d    = gnt1 ? req1_b : req0_b;
            end
         end
         StExec: begin
            exec_cnt_d = exec_cnt_q + 4'd1;
            if (exec_cnt_q == EXEC_LAST) begin
               state_d  = StResp;
               alu_op_d = OP_NOP;
               if (owner_q) begin
                  resp1_c_d    = alu_c;
                  resp1_zero_d = alu_zero[0];
               end else begin
                  resp0_c_d    = alu_c;
                  resp0_zero_d = alu_zero[0];
               end
            end
         end
         StResp: begin
            if (resp_hs) begin
               state_d   = StIdle;
               ops_cnt_d = ops_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= StIdle;
         owner_q      <= 1'b0;
         exec_cnt_q   <= 4'd0;
         alu_a_q      <= 32'd0;
         alu_b_q      <= 32'd0;
         alu_op_q     <= OP_NOP;
         resp0_c_q    <= 32'd0;
         resp0_zero_q <= 1'b0;
         resp1_c_q    <= 32'd0;
         resp1_zero_q <= 1'b0;
         ops_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         exec_cnt_q   <= exec_cnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         resp0_c_q    <= resp0_c_d;
         resp0_zero_q <= resp0_zero_d;
         resp1_c_q    <= resp1_c_d;
         resp1_zero_q <= resp1_zero_d;
         ops_cnt_q    <= ops_cnt_d;
      end
   end

   assign req0_ready  = gnt0;
   assign req1_ready  = gnt1;
   assign resp0_valid = (state_q == StResp) && !owner_q;
   assign resp1_valid = (state_q == StResp) && owner_q;
   assign resp0_c     = resp0_c_q;
   assign resp0_zero  = resp0_zero_q;
   assign resp1_c     = resp1_c_q;
   assign resp1_zero  = resp1_zero_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op      = alu_op_q;
   assign ops_cnt     = ops_cnt_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed bench for alu_share_ctrl.
// d1_* drives an instance with EXEC_CYCLES=1, d3_* one with EXEC_CYCLES=3.
// Inputs are driven at the falling edge; outputs are checked 1 time unit later.
module tb_alu_share_ctrl;
   import alu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // d1 instance signals
   logic        d1_rstn, d1_r0v, d1_r0r, d1_r1v, d1_r1r;
   logic [4:0]  d1_r0op, d1_r1op, d1_alu_op;
   logic [31:0] d1_r0a, d1_r0b, d1_r1a, d1_r1b;
   logic        d1_p0v, d1_p0r, d1_p0z, d1_p1v, d1_p1r, d1_p1z;
   logic [31:0] d1_p0c, d1_p1c, d1_alu_a, d1_alu_b, d1_alu_c;
   logic [7:0]  d1_alu_zero;
   logic [15:0] d1_ops;
   // d3 instance signals
   logic        d3_rstn, d3_r0v, d3_r0r, d3_r1v, d3_r1r;
   logic [4:0]  d3_r0op, d3_r1op, d3_alu_op;
   logic [31:0] d3_r0a, d3_r0b, d3_r1a, d3_r1b;
   logic        d3_p0v, d3_p0r, d3_p0z, d3_p1v, d3_p1r, d3_p1z;
   logic [31:0] d3_p0c, d3_p1c, d3_alu_a, d3_alu_b, d3_alu_c;
   logic [7:0]  d3_alu_zero;
   logic [15:0] d3_ops;

   alu_share_ctrl #(.EXEC_CYCLES(1), .CNT_W(16)) u_d1 (
      .clk(clk), .rstn(d1_rstn),
      .req0_valid(d1_r0v), .req0_ready(d1_r0r), .req0_op(d1_r0op), .req0_a(d1_r0a),
      .req0_b(d1_r0b),
      .req1_valid(d1_r1v), .req1_ready(d1_r1r), .req1_op(d1_r1op), .req1_a(d1_r1a),
      .req1_b(d1_r1b),
      .resp0_valid(d1_p0v), .resp0_ready(d1_p0r), .resp0_c(d1_p0c), .resp0_zero(d1_p0z),
      .resp1_valid(d1_p1v), .resp1_ready(d1_p1r), .resp1_c(d1_p1c), .resp1_zero(d1_p1z),
      .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_op(d1_alu_op), .alu_c(d1_alu_c),
      .alu_zero(d1_alu_zero), .ops_cnt(d1_ops)
   );

   alu_share_ctrl #(.EXEC_CYCLES(3), .CNT_W(16)) u_d3 (
      .clk(clk), .rstn(d3_rstn),
      .req0_valid(d3_r0v), .req0_ready(d3_r0r), .req0_op(d3_r0op), .req0_a(d3_r0a),
      .req0_b(d3_r0b),
      .req1_valid(d3_r1v), .req1_ready(d3_r1r), .req1_op(d3_r1op), .req1_a(d3_r1a),
      .req1_b(d3_r1b),
      .resp0_valid(d3_p0v), .resp0_ready(d3_p0r), .resp0_c(d3_p0c), .resp0_zero(d3_p0z),
      .resp1_valid(d3_p1v), .resp1_ready(d3_p1r), .resp1_c(d3_p1c), .resp1_zero(d3_p1z),
      .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_op(d3_alu_op), .alu_c(d3_alu_c),
      .alu_zero(d3_alu_zero), .ops_cnt(d3_ops)
   );

   // Behavioural stand-in for the shared ALU.
   function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      case (op)
         OP_LUI:         return b;
         OP_AUIPC, OP_ADD: return a + b;
         default:        return 32'd0;
      endcase
   endfunction

   always_comb begin
      d1_alu_c    = alu_model(d1_alu_op, d1_alu_a, d1_alu_b);
      d1_alu_zero = {7'd0, d1_alu_c == 32'd0};
      d3_alu_c    = alu_model(d3_alu_op, d3_alu_a, d3_alu_b);
      d3_alu_zero = {7'd0, d3_alu_c == 32'd0};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   int grants[4];
   int ngr;
   int both_hi;

   initial begin
      d1_rstn = 1'b0; d1_r0v = 1'b1; d1_r1v = 1'b0; d1_p0r = 1'b0; d1_p1r = 1'b0;
      d1_r0op = OP_NOP; d1_r0a = '0; d1_r0b = '0; d1_r1op = OP_NOP; d1_r1a = '0; d1_r1b = '0;
      d3_rstn = 1'b0; d3_r0v = 1'b0; d3_r1v = 1'b0; d3_p0r = 1'b0; d3_p1r = 1'b0;
      d3_r0op = OP_NOP; d3_r0a = '0; d3_r0b = '0; d3_r1op = OP_NOP; d3_r1a = '0; d3_r1b = '0;
      for (int i = 0; i < 4; i++) grants[i] = 2;

      // Reset state, with a request pending to show ready is suppressed.
      cyc(); #1;
      check("rst_req0_ready", d1_r0r, 0);
      check("rst_alu_op", d1_alu_op, OP_NOP);
      check("rst_alu_a", d1_alu_a, 0);
      check("rst_resp0_valid", d1_p0v, 0);
      check("rst_resp0_c", d1_p0c, 0);
      check("rst_ops_cnt", d1_ops, 0);
      d1_r0v = 1'b0;
      cyc(); d1_rstn = 1'b1; d3_rstn = 1'b1;
      cyc();

      // Single ADD on port 0.
      d1_r0v = 1'b1; d1_r0op = OP_ADD; d1_r0a = 32'd5; d1_r0b = 32'd7; d1_p0r = 1'b1;
      #1 check("t1_req0_ready", d1_r0r, 1);
      cyc(); d1_r0v = 1'b0;
      #1;
      check("t1_alu_a", d1_alu_a, 5);
      check("t1_alu_b", d1_alu_b, 7);
      check("t1_alu_op", d1_alu_op, 3);
      check("t1_resp0_early", d1_p0v, 0);
      cyc(); #1;
      check("t1_resp0_valid", d1_p0v, 1);
      check("t1_resp0_c", d1_p0c, 12);
      check("t1_resp0_zero", d1_p0z, 0);
      cyc(); #1;
      check("t1_resp0_drop", d1_p0v, 0);
      check("t1_ops_cnt", d1_ops, 1);
      check("t1_alu_op_nop", d1_alu_op, OP_NOP);

      // Port 1: -3 + 3 gives zero.
      d1_r1v = 1'b1; d1_r1op = OP_ADD; d1_r1a = 32'hFFFF_FFFD; d1_r1b = 32'd3; d1_p1r = 1'b1;
      #1;
      check("t2_req1_ready", d1_r1r, 1);
      check("t2_resp0_v_a", d1_p0v, 0);
      cyc(); d1_r1v = 1'b0;
      #1;
      check("t2_resp0_v_b", d1_p0v, 0);
      check("t2_resp1_early", d1_p1v, 0);
      cyc(); #1;
      check("t2_resp1_valid", d1_p1v, 1);
      check("t2_resp1_c", d1_p1c, 0);
      check("t2_resp1_zero", d1_p1z, 1);
      check("t2_resp0_v_c", d1_p0v, 0);
      cyc(); #1;
      check("t2_ops_cnt", d1_ops, 2);

      // Contention from reset: both ports valid continuously.
      d1_rstn = 1'b0;
      cyc(); d1_rstn = 1'b1;
      d1_r0v = 1'b1; d1_r0op = OP_ADD; d1_r0a = 32'd1; d1_r0b = 32'd1;
      d1_r1v = 1'b1; d1_r1op = OP_ADD; d1_r1a = 32'd2; d1_r1b = 32'd2;
      d1_p0r = 1'b1; d1_p1r = 1'b1;
      ngr = 0; both_hi = 0;
      for (int i = 0; i < 30 && ngr < 4; i++) begin
         #1;
         if (d1_r0r && d1_r1r) both_hi++;
         if (d1_r0r) begin
            grants[ngr] = 0; ngr++;
         end else if (d1_r1r) begin
            grants[ngr] = 1; ngr++;
         end
         cyc();
      end
      d1_r0v = 1'b0; d1_r1v = 1'b0;
      check("t3_grant_count", ngr, 4);
      check("t3_both_ready", both_hi, 0);
      for (int i = 0; i < 4; i++) check($sformatf("t3_grant%0d", i), grants[i], i % 2);
      cyc(); cyc(); #1;
      check("t3_ops_cnt", d1_ops, 4);

      // Backpressure on resp0 while port 1 waits.
      d1_r0v = 1'b1; d1_r0op = OP_ADD; d1_r0a = 32'd100; d1_r0b = 32'hFFFF_FFFF; d1_p0r = 1'b0;
      #1 check("t4_req0_ready", d1_r0r, 1);
      cyc(); d1_r0v = 1'b0;
      d1_r1v = 1'b1; d1_r1op = OP_ADD; d1_r1a = 32'd10; d1_r1b = 32'd20;
      #1 check("t4_req1_exec", d1_r1r, 0);
      cyc();
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("t4_hold_valid%0d", k), d1_p0v, 1);
         check($sformatf("t4_hold_c%0d", k), d1_p0c, 99);
         check($sformatf("t4_hold_zero%0d", k), d1_p0z, 0);
         check($sformatf("t4_hold_req1%0d", k), d1_r1r, 0);
         cyc();
      end
      d1_p0r = 1'b1;
      #1;
      check("t4_hs_req1", d1_r1r, 0);
      check("t4_hs_c", d1_p0c, 99);
      cyc(); #1;
      check("t4_after_valid", d1_p0v, 0);
      check("t4_after_req1", d1_r1r, 1);
      check("t4_ops_cnt", d1_ops, 5);
      cyc(); d1_r1v = 1'b0; d1_p1r = 1'b1;
      cyc(); #1;
      check("t4_resp1_valid", d1_p1v, 1);
      check("t4_resp1_c", d1_p1c, 30);
      cyc(); #1;
      check("t4_ops_final", d1_ops, 6);

      // Latency with EXEC_CYCLES=3.
      d3_r0v = 1'b1; d3_r0op = OP_AUIPC; d3_r0a = 32'h0000_1000; d3_r0b = 32'h0000_0004;
      d3_p0r = 1'b1;
      #1 check("t5_req0_ready", d3_r0r, 1);
      for (int k = 1; k <= 4; k++) begin
         cyc();
         if (k == 1) d3_r0v = 1'b0;
         #1 check($sformatf("t5_valid_at_%0d", k), d3_p0v, (k == 4) ? 1 : 0);
      end
      check("t5_resp0_c", d3_p0c, 32'h0000_1004);
      cyc(); #1;
      check("t5_ops_cnt", d3_ops, 1);
      check("t5_drop", d3_p0v, 0);

      // Reset during the second EXEC cycle.
      d3_r0v = 1'b1; d3_r0op = OP_ADD; d3_r0a = 32'd1; d3_r0b = 32'd2;
      #1 check("t6_req0_ready", d3_r0r, 1);
      cyc(); d3_r0v = 1'b0;
      cyc();
      d3_rstn = 1'b0;
      d3_r0v = 1'b1; d3_r0a = 32'd40; d3_r0b = 32'd2;
      d3_r1v = 1'b1; d3_r1op = OP_ADD; d3_r1a = 32'd7; d3_r1b = 32'd7;
      #1;
      check("t6_rst_alu_op", d3_alu_op, OP_NOP);
      check("t6_rst_resp0", d3_p0v, 0);
      check("t6_rst_resp1", d3_p1v, 0);
      check("t6_rst_ops", d3_ops, 0);
      check("t6_rst_ready0", d3_r0r, 0);
      check("t6_rst_ready1", d3_r1r, 0);
      cyc(); d3_rstn = 1'b1;
      #1;
      check("t6_rr_req0", d3_r0r, 1);
      check("t6_rr_req1", d3_r1r, 0);
      cyc(); d3_r0v = 1'b0; d3_r1v = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         #1 check($sformatf("t6_no_resp%0d", k), d3_p0v | d3_p1v, 0);
         cyc();
      end
      #1;
      check("t6_resp0_valid", d3_p0v, 1);
      check("t6_resp0_c", d3_p0c, 42);
      cyc(); #1;
      check("t6_ops_cnt", d3_ops, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
